fusion_out_packer: RTL and testbench

//  Downstream stage of the fusion datapath. Tracks beat validity through the fixed-latency

---
 rtl/lrf_pkg.sv | 23 ++
 rtl/lrf_fwft_fifo.sv | 54 +++++
 rtl/fusion_out_packer.sv | 101 ++++++++++
 tb/tb_fusion_out_packer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrf_pkg.sv
// Shared constants and helpers for the fusion datapath (fusion core and output packer).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lrf_pkg;

  // Advancing edges from input accept until the fused beat appears on fused_frame.
  localparam int FUSION_PIPE_LATENCY = 13;

  // Output sideband carried alongside each beat on the AXI4-Stream master.
  typedef struct packed {
    logic last;
    logic user;
  } axis_side_t;

  function automatic int data_width(input int input_width, input int pixels_per_beat);
    return input_width * pixels_per_beat;
  endfunction

  function automatic int beats_per_frame(input int dim, input int ppb);
    return (dim * dim) / ppb;
  endfunction

endpackage

// File: rtl/lrf_fwft_fifo.sv
// Generic first-word-fall-through FIFO: head entry is visible on pop_dat while !empty.
// Latency: a push is visible at the head on the edge after it is written (if FIFO was empty).
// Backpressure: push ignored when full, pop ignored when empty; caller owns flow control.
// Ports: clk/rst (async active-high), push/push_dat, pop/pop_dat, full, empty, count.
module lrf_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  // Storage carries no reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fusion_out_packer.sv
// Tracks beat validity through the fusion pipeline, buffers fused beats, emits AXI4-Stream with SOF/EOF.
// Latency: tvalid rises PIPE_LATENCY+1 edges after the accepting edge when unthrottled.
// Backpressure: registered stall freezes the pipeline once the FIFO has a single free slot left.
// Ports: clk, areset; s_valid/s_ready upstream; stall to pipeline; fused_frame from fusion;
//        m_axis_* master; frame_done pulse; err_overflow sticky error.
module fusion_out_packer
  import lrf_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int INPUT_WIDTH     = 8,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = data_width(INPUT_WIDTH, PIXELS_PER_BEAT),
  parameter int PIPE_LATENCY    = FUSION_PIPE_LATENCY,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  stall,
  input  logic [DATA_WIDTH-1:0] fused_frame,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic                  err_overflow
);

  localparam int BPF = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int BW  = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] LAST_BEAT   = BW'(BPF - 1);
  localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - 1);

  logic [PIPE_LATENCY-1:0] vsr;
  logic                    pipe_valid;
  logic                    push;
  logic                    handshake;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           count_next;
  logic [BW-1:0]           beat_cnt;
  axis_side_t              side;

  assign pipe_valid    = vsr[PIPE_LATENCY-1];
  assign push          = ~stall & pipe_valid;
  assign s_ready       = ~stall;
  assign m_axis_tvalid = ~fifo_empty;
  assign handshake     = m_axis_tvalid & m_axis_tready;

  // Sideband follows the beat counter, which only moves on a handshake, so it stays
  // stable with tdata while the beat is held. Gated so both read 0 when idle.
  assign side.user    = m_axis_tvalid & (beat_cnt == '0);
  assign side.last    = m_axis_tvalid & (beat_cnt == LAST_BEAT);
  assign m_axis_tuser = side.user;
  assign m_axis_tlast = side.last;

  lrf_fwft_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (areset),
    .push     (push),
    .push_dat (fused_frame),
    .pop      (handshake),
    .pop_dat  (m_axis_tdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Occupancy after this edge; an overflowing push is dropped and does not count.
  always_comb begin
    count_next = fifo_count;
    if ((push & ~fifo_full) && !handshake)      count_next = fifo_count + CW'(1);
    else if (!(push & ~fifo_full) && handshake) count_next = fifo_count - CW'(1);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vsr          <= '0;
      stall        <= 1'b0;
      beat_cnt     <= '0;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      // Valid tracking freezes together with the fusion pipeline.
      if (!stall) vsr <= {vsr[PIPE_LATENCY-2:0], s_valid};
      // Stall while at most one slot is free: any unstalled cycle can push at most once.
      stall <= (count_next >= STALL_LEVEL);
      if (handshake) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
      frame_done <= handshake & side.last;
      if (push && fifo_full) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fusion_out_packer.sv
// Self-checking bench for fusion_out_packer: emulates the frozen-on-stall fusion pipeline,
// keeps a queue of accepted beats as the reference, and checks order, SOF/EOF marking,
// frame_done, hold stability, stall/ready behaviour, latency and reset.
module tb_fusion_out_packer;

  localparam int PPB = 16;
  localparam int IW  = 8;
  localparam int DIM = 64;
  localparam int DW  = PPB * IW;
  localparam int LAT = 13;
  localparam int FD  = 8;
  localparam int BPF = DIM * DIM / PPB;

  logic          clk = 1'b0;
  logic          areset;
  logic          s_valid;
  logic          s_ready;
  logic          stall;
  logic [DW-1:0] fused_frame;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          frame_done;
  logic          err_overflow;

  fusion_out_packer #(
    .PIXELS_PER_BEAT (PPB),
    .INPUT_WIDTH     (IW),
    .IMAGE_DIM       (DIM),
    .DATA_WIDTH      (DW),
    .PIPE_LATENCY    (LAT),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .stall         (stall),
    .fused_frame   (fused_frame),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_done    (frame_done),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sv_pct;       // -1: alternate every cycle
    int    rdy_pct;      // -1: three cycles on, three off
    int    cycles;
    bit    chk_end;
    bit    exp_stall;
    int    exp_inflight;
  } row_t;

  logic [DW-1:0] s_data;
  logic [DW-1:0] pipe_m [LAT];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] prev_dat;
  logic          prev_user, prev_last;
  bit            prev_hold, exp_fd;
  int            beat_idx, n_acc, n_out, frames_seen, cyc;
  int            first_acc, first_tv;
  int            total, bad;

  function automatic logic [DW-1:0] gen_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_stim(input int sv_pct, input int rdy_pct);
    s_valid       = (sv_pct < 0) ? cyc[0] : (int'($urandom_range(99)) < sv_pct);
    s_data        = gen_data();
    m_axis_tready = (rdy_pct < 0) ? ((cyc / 3) % 2 == 0) : (int'($urandom_range(99)) < rdy_pct);
  endtask

  // One clock: sample/check at the falling edge, then update the pipeline emulation after the rise.
  task automatic cycle();
    bit acc, hs, adv;
    @(negedge clk);
    adv = !stall;
    acc = s_valid && !stall;
    hs  = m_axis_tvalid && m_axis_tready;
    chk("s_ready_vs_stall", s_ready, !stall);
    chk("frame_done", frame_done, exp_fd);
    chk("err_overflow", err_overflow, 0);
    if (frame_done) frames_seen++;
    if (prev_hold) begin
      chk("hold_tvalid", m_axis_tvalid, 1);
      chk("hold_tdata", m_axis_tdata, prev_dat);
      chk("hold_tuser", m_axis_tuser, prev_user);
      chk("hold_tlast", m_axis_tlast, prev_last);
    end
    if (m_axis_tvalid) begin
      if (exp_q.size() == 0) chk("spurious_tvalid", m_axis_tvalid, 0);
      else chk("tdata_order", m_axis_tdata, exp_q[0]);
      chk("tuser", m_axis_tuser, beat_idx == 0);
      chk("tlast", m_axis_tlast, beat_idx == BPF - 1);
      if (first_tv < 0) first_tv = cyc;
    end
    exp_fd = hs && (beat_idx == BPF - 1);
    if (hs) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      beat_idx = (beat_idx + 1) % BPF;
      n_out++;
    end
    prev_hold = m_axis_tvalid && !m_axis_tready;
    prev_dat  = m_axis_tdata;
    prev_user = m_axis_tuser;
    prev_last = m_axis_tlast;
    if (acc) begin
      exp_q.push_back(s_data);
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    @(posedge clk);
    #1;
    if (adv) begin
      for (int i = LAT - 1; i > 0; i--) pipe_m[i] = pipe_m[i-1];
      pipe_m[0] = s_data;
    end
    fused_frame = pipe_m[LAT-1];
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    s_valid       = 1'b0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 400) begin
      s_data = gen_data();
      cycle();
      n++;
    end
    cycle();
    cycle();
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_out_eq_acc"}, n_out, n_acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rst_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_rst_stall"}, stall, 0);
    chk({tag, "_rst_s_ready"}, s_ready, 1);
    chk({tag, "_rst_tuser"}, m_axis_tuser, 0);
    chk({tag, "_rst_tlast"}, m_axis_tlast, 0);
    chk({tag, "_rst_frame_done"}, frame_done, 0);
    chk({tag, "_rst_err"}, err_overflow, 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    beat_idx  = 0;
    exp_fd    = 0;
    prev_hold = 0;
    n_acc     = 0;
    n_out     = 0;
  endtask

  initial begin
    row_t rows [4];
    int   n, base;

    rows[0] = '{"steady",    100, 100,   60, 1'b1, 1'b0, LAT + 1};
    rows[1] = '{"blocked",   100,   0,   40, 1'b1, 1'b1, LAT + FD - 1};
    rows[2] = '{"alternate",  -1,  -1,  200, 1'b0, 1'b0, 0};
    rows[3] = '{"random",     70,  50, 2400, 1'b0, 1'b0, 0};

    total = 0; bad = 0; cyc = 0; frames_seen = 0;
    first_acc = -1; first_tv = -1;
    areset = 1'b1; s_valid = 1'b0; m_axis_tready = 1'b0;
    s_data = '0; fused_frame = '0;
    for (int i = 0; i < LAT; i++) pipe_m[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 areset = 1'b0;
    check_reset_outputs("init");

    // One full frame, unthrottled: latency, SOF/EOF and a single frame_done.
    m_axis_tready = 1'b1;
    n = 0;
    while (n_acc < BPF && n < BPF + 100) begin
      s_valid = 1'b1;
      s_data  = gen_data();
      cycle();
      n++;
    end
    drain("frame1");
    chk("frame1_latency", first_tv - first_acc, LAT + 1);
    chk("frame1_beats", n_out, BPF);
    chk("frame1_frame_done_count", frames_seen, 1);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < rows[r].cycles; c++) begin
        set_stim(rows[r].sv_pct, rows[r].rdy_pct);
        cycle();
      end
      if (rows[r].chk_end) begin
        chk({rows[r].name, "_stall"}, stall, rows[r].exp_stall);
        chk({rows[r].name, "_s_ready"}, s_ready, !rows[r].exp_stall);
        chk({rows[r].name, "_inflight"}, exp_q.size(), rows[r].exp_inflight);
      end
      drain(rows[r].name);
    end

    // tready dropouts of growing length against a continuous push stream.
    for (int k = 0; k < 8; k++) begin
      repeat (k + 3) begin s_valid = 1'b1; s_data = gen_data(); m_axis_tready = 1'b1; cycle(); end
      repeat (k + 1) begin s_valid = 1'b1; s_data = gen_data(); m_axis_tready = 1'b0; cycle(); end
    end
    drain("pulses");

    // Reset mid-frame with beats in the FIFO and the pipeline.
    base = n_out;
    n = 0;
    m_axis_tready = 1'b1;
    while (n_out - base < 100 && n < 300) begin
      s_valid = 1'b1;
      s_data  = gen_data();
      cycle();
      n++;
    end
    chk("midreset_reached_beat100", (n_out - base) >= 100, 1);
    repeat (4) begin s_valid = 1'b1; s_data = gen_data(); m_axis_tready = 1'b0; cycle(); end
    chk("midreset_tvalid_before", m_axis_tvalid, 1);
    #1 areset = 1'b1;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 areset = 1'b0;
    m_axis_tready = 1'b1;
    n = 0;
    while (!m_axis_tvalid && n < 40) begin
      s_valid = 1'b1;
      s_data  = gen_data();
      cycle();
      n++;
    end
    chk("postreset_tvalid", m_axis_tvalid, 1);
    chk("postreset_first_tuser", m_axis_tuser, 1);
    repeat (30) begin s_valid = 1'b1; s_data = gen_data(); cycle(); end
    drain("postreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
